// File: rtl/key_debounce_pkg.sv
// Shared types and default timing for the push-button conditioner.
package key_debounce_pkg;

  // Per-channel hold tracking: idle, pressed before long-press, auto-repeating.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    RPT  = 2'd2
  } hold_state_t;

  // Default timing, in 1 kHz clock cycles.
  localparam int unsigned DEF_NUM_KEYS    = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DEBOUNCE_MS = 10;
  localparam int unsigned DEF_HOLD_MS     = 1000;
  localparam int unsigned DEF_REPEAT_MS   = 200;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: synchroniser, debounce filter, edge pulses and hold/repeat FSM.
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int unsigned HOLD_MS     = DEF_HOLD_MS,
  parameter int unsigned REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic CLK1K,
  input  logic RSTN,
  input  logic KEY_N,
  input  logic REPEAT_EN,
  output logic KEY_LEVEL,
  output logic KEY_PRESS,
  output logic KEY_RELEASE,
  output logic KEY_LONG,
  output logic KEY_REPEAT
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned HC_W  = $clog2(max_u(HOLD_MS, REPEAT_MS));

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_MS);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_MS - 1);
  localparam logic [HC_W-1:0]  REP_LAST  = HC_W'(REPEAT_MS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   cand;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;
  logic                   press_acc;
  logic                   rel_acc;
  hold_state_t            state;
  logic [HC_W-1:0]        hcnt;

  // Synchronise the raw active-low input; reset value reads as released.
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], KEY_N};
    end
  end

  assign s = ~sync[SYNC_STAGES-1];

  // Level change is accepted once the candidate has been stable for DEBOUNCE_MS samples.
  always_comb begin
    accept    = 1'b0;
    press_acc = 1'b0;
    rel_acc   = 1'b0;
    if ((s == cand) && (cnt == CNT_MAX) && (cand != KEY_LEVEL)) begin
      accept = 1'b1;
    end
    press_acc = accept & cand;
    rel_acc   = accept & ~cand;
  end

  // Debounce filter: restart on any disagreement, saturate the stability count.
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      cand        <= 1'b0;
      cnt         <= '0;
      KEY_LEVEL   <= 1'b0;
      KEY_PRESS   <= 1'b0;
      KEY_RELEASE <= 1'b0;
    end else begin
      KEY_PRESS   <= press_acc;
      KEY_RELEASE <= rel_acc;
      if (s != cand) begin
        cand <= s;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end else if (accept) begin
        KEY_LEVEL <= cand;
      end
    end
  end

  // Hold FSM: long-press after HOLD_MS, then periodic repeat; release always wins.
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      hcnt       <= '0;
      KEY_LONG   <= 1'b0;
      KEY_REPEAT <= 1'b0;
    end else begin
      KEY_LONG   <= 1'b0;
      KEY_REPEAT <= 1'b0;
      if (rel_acc) begin
        state <= IDLE;
        hcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press_acc) begin
              state <= HELD;
              hcnt  <= '0;
            end
          end
          HELD: begin
            if (hcnt == HOLD_LAST) begin
              KEY_LONG <= 1'b1;
              hcnt     <= '0;
              state    <= RPT;
            end else begin
              hcnt <= hcnt + HC_W'(1);
            end
          end
          RPT: begin
            if (hcnt == REP_LAST) begin
              hcnt       <= '0;
              KEY_REPEAT <= REPEAT_EN;
            end else begin
              hcnt <= hcnt + HC_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            hcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_debounce_array.sv
// Multi-channel push-button conditioner: NUM_KEYS independent debounce channels.
module key_debounce_array
  import key_debounce_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = DEF_NUM_KEYS,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int unsigned HOLD_MS     = DEF_HOLD_MS,
  parameter int unsigned REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic                CLK1K,
  input  logic                RSTN,
  input  logic [NUM_KEYS-1:0] KEY_N,
  input  logic [NUM_KEYS-1:0] REPEAT_EN,
  output logic [NUM_KEYS-1:0] KEY_LEVEL,
  output logic [NUM_KEYS-1:0] KEY_PRESS,
  output logic [NUM_KEYS-1:0] KEY_RELEASE,
  output logic [NUM_KEYS-1:0] KEY_LONG,
  output logic [NUM_KEYS-1:0] KEY_REPEAT
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .HOLD_MS    (HOLD_MS),
      .REPEAT_MS  (REPEAT_MS)
    ) u_chan (
      .CLK1K      (CLK1K),
      .RSTN       (RSTN),
      .KEY_N      (KEY_N[i]),
      .REPEAT_EN  (REPEAT_EN[i]),
      .KEY_LEVEL  (KEY_LEVEL[i]),
      .KEY_PRESS  (KEY_PRESS[i]),
      .KEY_RELEASE(KEY_RELEASE[i]),
      .KEY_LONG   (KEY_LONG[i]),
      .KEY_REPEAT (KEY_REPEAT[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed self-checking bench for key_debounce_array (DEBOUNCE 10, HOLD 20, REPEAT 5).
module tb_key_debounce_array;

  logic       CLK1K = 1'b0;
  logic       RSTN;
  logic [3:0] KEY_N;
  logic [3:0] REPEAT_EN;
  logic [3:0] KEY_LEVEL;
  logic [3:0] KEY_PRESS;
  logic [3:0] KEY_RELEASE;
  logic [3:0] KEY_LONG;
  logic [3:0] KEY_REPEAT;

  int vectors     = 0;
  int miscompares = 0;
  int n_press[4];
  int n_rel[4];
  int n_long[4];
  int n_rep[4];

  always #5 CLK1K = ~CLK1K;

  key_debounce_array #(
    .NUM_KEYS   (4),
    .SYNC_STAGES(2),
    .DEBOUNCE_MS(10),
    .HOLD_MS    (20),
    .REPEAT_MS  (5)
  ) dut (
    .CLK1K      (CLK1K),
    .RSTN       (RSTN),
    .KEY_N      (KEY_N),
    .REPEAT_EN  (REPEAT_EN),
    .KEY_LEVEL  (KEY_LEVEL),
    .KEY_PRESS  (KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE),
    .KEY_LONG   (KEY_LONG),
    .KEY_REPEAT (KEY_REPEAT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    for (int k = 0; k < 4; k++) begin
      n_press[k] = 0;
      n_rel[k]   = 0;
      n_long[k]  = 0;
      n_rep[k]   = 0;
    end
  endtask

  // One clock edge, sample 1 time unit later, tally pulses and check exclusivity.
  task automatic step();
    @(posedge CLK1K);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_press[k] += int'(KEY_PRESS[k]);
      n_rel[k]   += int'(KEY_RELEASE[k]);
      n_long[k]  += int'(KEY_LONG[k]);
      n_rep[k]   += int'(KEY_REPEAT[k]);
    end
    chk("press_rel_excl", 32'(KEY_PRESS & KEY_RELEASE), 32'h0);
    chk("long_rep_excl", 32'(KEY_LONG & KEY_REPEAT), 32'h0);
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  initial begin
    RSTN      = 1'b0;
    KEY_N     = 4'hF;
    REPEAT_EN = 4'h0;
    #12;
    chk("rst_level", 32'(KEY_LEVEL), 32'h0);
    chk("rst_press", 32'(KEY_PRESS), 32'h0);
    chk("rst_long", 32'(KEY_LONG), 32'h0);
    step();
    RSTN = 1'b1;
    steps(3);
    chk("idle_level", 32'(KEY_LEVEL), 32'h0);
    chk("idle_release", 32'(KEY_RELEASE), 32'h0);
    chk("idle_repeat", 32'(KEY_REPEAT), 32'h0);

    // Clean press on key 0: pulse only at edge 14.
    clr_cnt();
    KEY_N[0] = 1'b0;
    steps(13);
    chk("t1_press_e13", 32'(KEY_PRESS), 32'h0);
    chk("t1_level_e13", 32'(KEY_LEVEL), 32'h0);
    step();
    chk("t1_press_e14", 32'(KEY_PRESS), 32'h1);
    chk("t1_level_e14", 32'(KEY_LEVEL), 32'h1);
    step();
    chk("t1_press_e15", 32'(KEY_PRESS), 32'h0);
    chk("t1_level_e15", 32'(KEY_LEVEL), 32'h1);
    KEY_N[0] = 1'b1;
    steps(13);
    chk("t1_rel_early", 32'(KEY_RELEASE), 32'h0);
    chk("t1_level_held", 32'(KEY_LEVEL), 32'h1);
    step();
    chk("t1_release", 32'(KEY_RELEASE), 32'h1);
    chk("t1_level_rel", 32'(KEY_LEVEL), 32'h0);
    chk("t1_npress", 32'(n_press[0]), 32'd1);
    steps(20);

    // Bounce on key 1: toggle every 3 cycles, then held low.
    clr_cnt();
    for (int i = 0; i < 10; i++) begin
      KEY_N[1] = (i % 2 == 1);
      steps(3);
    end
    KEY_N[1] = 1'b0;
    steps(13);
    chk("t2_no_early_press", 32'(n_press[1]), 32'd0);
    step();
    chk("t2_press", 32'(KEY_PRESS), 32'h2);
    chk("t2_npress", 32'(n_press[1]), 32'd1);
    step();
    KEY_N[1] = 1'b1;
    steps(14);
    chk("t2_release", 32'(KEY_RELEASE), 32'h2);
    chk("t2_nlong", 32'(n_long[1]), 32'd0);
    steps(20);

    // Hold key 2 with repeat enabled, then disable repeat.
    clr_cnt();
    REPEAT_EN[2] = 1'b1;
    KEY_N[2]     = 1'b0;
    steps(14);
    chk("t3_press", 32'(KEY_PRESS), 32'h4);
    steps(19);
    chk("t3_long_early", 32'(KEY_LONG), 32'h0);
    step();
    chk("t3_long", 32'(KEY_LONG), 32'h4);
    steps(4);
    chk("t3_rep_early", 32'(KEY_REPEAT), 32'h0);
    step();
    chk("t3_rep1", 32'(KEY_REPEAT), 32'h4);
    step();
    chk("t3_rep1_clear", 32'(KEY_REPEAT), 32'h0);
    steps(4);
    chk("t3_rep2", 32'(KEY_REPEAT), 32'h4);
    steps(5);
    chk("t3_rep3", 32'(KEY_REPEAT), 32'h4);
    REPEAT_EN[2] = 1'b0;
    steps(11);
    chk("t3_nrep_gated", 32'(n_rep[2]), 32'd3);
    chk("t3_nlong", 32'(n_long[2]), 32'd1);
    KEY_N[2] = 1'b1;
    steps(14);
    chk("t3_release", 32'(KEY_RELEASE), 32'h4);
    chk("t3_level_rel", 32'(KEY_LEVEL), 32'h0);
    steps(20);

    // Release on key 3 lands on the LONG edge: release wins, FSM idles.
    clr_cnt();
    REPEAT_EN[3] = 1'b1;
    KEY_N[3]     = 1'b0;
    steps(14);
    chk("t4_press", 32'(KEY_PRESS), 32'h8);
    steps(6);
    KEY_N[3] = 1'b1;
    steps(14);
    chk("t4_release", 32'(KEY_RELEASE), 32'h8);
    chk("t4_no_long", 32'(KEY_LONG), 32'h0);
    steps(40);
    chk("t4_nlong", 32'(n_long[3]), 32'd0);
    chk("t4_nrep", 32'(n_rep[3]), 32'd0);
    REPEAT_EN = 4'h0;

    // Reset mid-hold on key 0 while the key stays down.
    clr_cnt();
    KEY_N[0] = 1'b0;
    steps(14);
    chk("t5_press", 32'(KEY_PRESS), 32'h1);
    steps(20);
    chk("t5_long", 32'(KEY_LONG), 32'h1);
    RSTN = 1'b0;
    #1;
    chk("t5_rst_long", 32'(KEY_LONG), 32'h0);
    chk("t5_rst_level", 32'(KEY_LEVEL), 32'h0);
    step();
    chk("t5_rst_press", 32'(KEY_PRESS), 32'h0);
    RSTN = 1'b1;
    steps(13);
    chk("t5_repress_early", 32'(KEY_PRESS), 32'h0);
    step();
    chk("t5_repress", 32'(KEY_PRESS), 32'h1);
    chk("t5_relevel", 32'(KEY_LEVEL), 32'h1);
    step();
    KEY_N[0] = 1'b1;
    steps(14);
    chk("t5_release", 32'(KEY_RELEASE), 32'h1);
    steps(20);

    // All four keys pressed together.
    KEY_N = 4'h0;
    steps(13);
    chk("t6_press_early", 32'(KEY_PRESS), 32'h0);
    step();
    chk("t6_press_all", 32'(KEY_PRESS), 32'hF);
    chk("t6_level_all", 32'(KEY_LEVEL), 32'hF);
    step();
    KEY_N = 4'hF;
    steps(14);
    chk("t6_release_all", 32'(KEY_RELEASE), 32'hF);
    chk("t6_level_none", 32'(KEY_LEVEL), 32'h0);
    steps(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
